// File: rtl/out_port_unit_if.sv
// out_port_unit_if
//   Bundles the OUT-instruction request path and the eight external port
//   handshakes of out_port_unit.
//   master : pipeline / device side (drives LOP, pn, od, port_ack)
//   slave  : out_port_unit (drives stall, port_data, port_vld, ovf)
//   LOP        load-output request, one per cycle sampled high
//   pn         3-bit destination port number
//   od         8-bit data byte
//   stall      request FIFO full
//   port_data  eight 8-bit port registers, port p at [8p+7:8p]
//   port_vld   per-port valid strobe, one-hot or zero
//   port_ack   per-port acknowledge from the external devices
//   ovf        sticky: a request was dropped
interface out_port_unit_if;
   logic        LOP;
   logic [2:0]  pn;
   logic [7:0]  od;
   logic        stall;
   logic [63:0] port_data;
   logic [7:0]  port_vld;
   logic [7:0]  port_ack;
   logic        ovf;

   modport master (
      output LOP, pn, od, port_ack,
      input  stall, port_data, port_vld, ovf
   );

   modport slave (
      input  LOP, pn, od, port_ack,
      output stall, port_data, port_vld, ovf
   );
endinterface

// File: rtl/out_port_unit.sv
// out_port_unit
//   Buffers OUT-instruction requests {pn, od} in a 4-entry FIFO and drains
//   them one at a time into eight port registers, each write followed by a
//   valid/acknowledge handshake on the addressed port.
//   clk    global clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    out_port_unit_if.slave (LOP, pn, od, port_ack in;
//          stall, port_data, port_vld, ovf out)
module out_port_unit (
   input  logic             clk,
   input  logic             rst_n,
   out_port_unit_if.slave   bus
);

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } state_t;

   state_t      state_q,  state_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q,  count_d;
   logic [2:0]  pn_mem_q [4];
   logic [2:0]  pn_mem_d [4];
   logic [7:0]  od_mem_q [4];
   logic [7:0]  od_mem_d [4];
   logic [7:0]  port_q   [8];
   logic [7:0]  port_d   [8];
   logic [7:0]  vld_q,    vld_d;
   logic [2:0]  cur_pn_q, cur_pn_d;
   logic        ovf_q,    ovf_d;

   logic        pop;
   logic        push;
   logic [2:0]  head_pn;
   logic [7:0]  head_od;
   logic [63:0] port_data_flat;

   assign head_pn = pn_mem_q[rd_ptr_q];
   assign head_od = od_mem_q[rd_ptr_q];

   always_comb begin
      // The drain side pops whenever it is idle with data queued; a pop in
      // the same cycle frees a slot, so a push at full is still accepted.
      pop  = (state_q == IDLE) && (count_q != 3'd0);
      push = bus.LOP && ((count_q != 3'd4) || pop);

      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pn_mem_d = pn_mem_q;
      od_mem_d = od_mem_q;
      port_d   = port_q;
      vld_d    = vld_q;
      cur_pn_d = cur_pn_q;
      ovf_d    = ovf_q;

      // At full with a pop, wr_ptr == rd_ptr: the head is read from the
      // current register contents before the new entry overwrites the slot.
      if (push) begin
         pn_mem_d[wr_ptr_q] = bus.pn;
         od_mem_d[wr_ptr_q] = bus.od;
         wr_ptr_d           = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      if (bus.LOP && !push) begin
         ovf_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               port_d[head_pn] = head_od;
               vld_d           = 8'd1 << head_pn;
               cur_pn_d        = head_pn;
               state_d         = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (bus.port_ack[cur_pn_q]) begin
               vld_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            vld_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pn_mem_q <= '{default: '0};
         od_mem_q <= '{default: '0};
         port_q   <= '{default: '0};
         vld_q    <= '0;
         cur_pn_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pn_mem_q <= pn_mem_d;
         od_mem_q <= od_mem_d;
         port_q   <= port_d;
         vld_q    <= vld_d;
         cur_pn_q <= cur_pn_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      port_data_flat = '0;
      for (int unsigned p = 0; p < 8; p++) begin
         port_data_flat[8*p +: 8] = port_q[p];
      end
   end

   assign bus.stall     = (count_q == 3'd4);
   assign bus.port_data = port_data_flat;
   assign bus.port_vld  = vld_q;
   assign bus.ovf       = ovf_q;

endmodule
